// File: rtl/pe_pkg.sv
// Shared types and constants for the systolic PE: stage-1 record and saturation limits.
// The stage-1 product field is sized for the widest supported operand (DATA_W <= 31).
package pe_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 32;
    localparam int PROD_MAX_W = 64;
    localparam int ACC_MAX_W  = 128;

    typedef struct packed {
        logic signed [PROD_MAX_W-1:0] product;
        logic                         valid;
        logic                         first;
    } stage1_t;

    // Largest (neg=0) or smallest (neg=1) two's-complement value of acc_w bits,
    // returned in the low acc_w bits of a ACC_MAX_W-wide vector.
    function automatic logic [ACC_MAX_W-1:0] sat_limit(input int acc_w, input logic neg);
        logic [ACC_MAX_W-1:0] lim;
        lim = '0;
        for (int i = 0; i < ACC_MAX_W; i++) begin
            if (i < acc_w - 1) begin
                lim[i] = 1'b1;
            end
        end
        if (neg) begin
            lim = ~lim;
        end
        return lim;
    endfunction

endpackage

// File: rtl/pe_mul_stage.sv
// Operand extension and multiply, optionally registered as stage 1.
// Latency PIPE_MUL cycles; holds contents while enable=0, no backpressure.
// Invalid terms are zeroed here so downstream never sees a stray product.
module pe_mul_stage
    import pe_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int PIPE_MUL = 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              enable,
    input  logic              unsigned_mode,
    input  logic              push,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              a_valid,
    input  logic              b_valid,
    output stage1_t           s1
);

    logic signed [DATA_W:0]     a_ext;
    logic signed [DATA_W:0]     b_ext;
    logic signed [2*DATA_W+1:0] prod;
    stage1_t                    nxt;

    assign a_ext = {~unsigned_mode & a[DATA_W-1], a};
    assign b_ext = {~unsigned_mode & b[DATA_W-1], b};
    assign prod  = a_ext * b_ext;

    always_comb begin
        nxt         = '0;
        nxt.valid   = a_valid & b_valid;
        nxt.first   = push & a_valid & b_valid;
        nxt.product = nxt.valid ? PROD_MAX_W'(prod) : '0;
    end

    generate
        if (PIPE_MUL != 0) begin : g_reg
            always_ff @(posedge clk) begin
                if (clear) begin
                    s1 <= '0;
                end else if (enable) begin
                    s1 <= nxt;
                end
            end
        end else begin : g_comb
            assign s1 = nxt;
        end
    endgenerate

endmodule

// File: rtl/pe_systolic_param.sv
// Output-stationary systolic PE: MAC with saturating/wrapping accumulate and drain chain.
// Latency: operands forward in 1 cycle, term reaches out_c after 1+PIPE_MUL enabled edges.
// No backpressure; enable=0 freezes every register, reset/start clear regardless.
module pe_systolic_param
    import pe_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int PIPE_MUL  = 1,
    parameter int SATURATE  = 1,
    parameter int HAS_A_OUT = 1,
    parameter int HAS_B_OUT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              enable,
    input  logic              push,
    input  logic              unsigned_mode,
    input  logic              drain,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_a_valid,
    input  logic              in_b_valid,
    input  logic [ACC_W-1:0]  in_c,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              out_a_valid,
    output logic              out_b_valid,
    output logic [ACC_W-1:0]  out_c,
    output logic              ovf,
    output logic              collide
);

    generate
        if (ACC_W < 2*DATA_W + 2) begin : g_bad_acc_w
            $error("pe_systolic_param: ACC_W must be >= 2*DATA_W+2");
        end
        if (ACC_W > ACC_MAX_W || 2*DATA_W + 2 > PROD_MAX_W) begin : g_bad_width
            $error("pe_systolic_param: width exceeds package limits");
        end
    endgenerate

    localparam logic [ACC_MAX_W-1:0] SAT_MAX_FULL = sat_limit(ACC_W, 1'b0);
    localparam logic [ACC_MAX_W-1:0] SAT_MIN_FULL = sat_limit(ACC_W, 1'b1);
    localparam logic [ACC_W-1:0]     SAT_MAX      = SAT_MAX_FULL[ACC_W-1:0];
    localparam logic [ACC_W-1:0]     SAT_MIN      = SAT_MIN_FULL[ACC_W-1:0];

    logic                    clr;
    stage1_t                 s1;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W:0]   sum;
    logic                    sum_ovf;
    logic        [ACC_W-1:0] sum_res;

    assign clr = reset | start;

    pe_mul_stage #(
        .DATA_W   (DATA_W),
        .PIPE_MUL (PIPE_MUL)
    ) u_mul (
        .clk           (clk),
        .clear         (clr),
        .enable        (enable),
        .unsigned_mode (unsigned_mode),
        .push          (push),
        .a             (in_a),
        .b             (in_b),
        .a_valid       (in_a_valid),
        .b_valid       (in_b_valid),
        .s1            (s1)
    );

    assign prod_ext = ACC_W'($signed(s1.product));

    // One extra bit exposes overflow as a disagreement between the top two bits.
    always_comb begin
        sum     = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
        sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
        sum_res = sum[ACC_W-1:0];
        if (sum_ovf && (SATURATE != 0)) begin
            sum_res = sum[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            acc_q   <= '0;
            ovf     <= 1'b0;
            collide <= 1'b0;
        end else if (enable) begin
            if (drain) begin
                acc_q <= in_c;
                if (s1.valid) begin
                    collide <= 1'b1;
                end
            end else if (s1.valid && s1.first) begin
                acc_q <= prod_ext;
            end else if (s1.valid) begin
                acc_q <= sum_res;
                if (sum_ovf) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    assign out_c = acc_q;

    generate
        if (HAS_A_OUT != 0) begin : g_a_out
            always_ff @(posedge clk) begin
                if (clr) begin
                    out_a       <= '0;
                    out_a_valid <= 1'b0;
                end else if (enable) begin
                    out_a       <= in_a;
                    out_a_valid <= in_a_valid;
                end
            end
        end else begin : g_a_tie
            assign out_a       = '0;
            assign out_a_valid = 1'b0;
        end

        if (HAS_B_OUT != 0) begin : g_b_out
            always_ff @(posedge clk) begin
                if (clr) begin
                    out_b       <= '0;
                    out_b_valid <= 1'b0;
                end else if (enable) begin
                    out_b       <= in_b;
                    out_b_valid <= in_b_valid;
                end
            end
        end else begin : g_b_tie
            assign out_b       = '0;
            assign out_b_valid = 1'b0;
        end
    endgenerate

endmodule
